// File: rtl/instr_seq_ctrl.sv
// Multi-cycle fetch/decode/execute sequencer for the 16-bit Thumb-subset core.
// Optional MEM_TIMEOUT_EN adds a bounded handshake wait with a sticky bus_err.
module instr_seq_ctrl #(
    parameter int unsigned PC_STEP    = 1,
    parameter int unsigned PUSH_BEATS = 2
`ifdef MEM_TIMEOUT_EN
    , parameter int unsigned TIMEOUT  = 255
`endif
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       start,
    input  logic       halt_req,
    output logic       imem_req,
    input  logic       imem_ack,
    output logic       ir_load,
    input  logic [3:0] opcode,
    input  logic       cond_true,
    output logic       alu_en,
    output logic       flag_we,
    output logic       reg_we,
    output logic       sp_we,
    output logic       pc_inc,
    output logic       pc_load,
    output logic       dmem_req,
    output logic       dmem_we,
    output logic       dmem_byte,
    input  logic       dmem_ack,
    output logic       beat,
    output logic       busy,
    output logic [3:0] state_o
`ifdef MEM_TIMEOUT_EN
    , output logic     bus_err
`endif
);

    localparam int unsigned BEAT_W = (PUSH_BEATS > 1) ? $clog2(PUSH_BEATS) : 1;

    // Opcode class tables, one bit per opcode
    localparam logic [15:0] ALU_OPS   = 16'hEAFF;
    localparam logic [15:0] FLAG_OPS  = 16'h8818;
    localparam logic [15:0] MEM_OPS   = 16'h60C3;
    localparam logic [15:0] WR_OPS    = 16'h2081;
    localparam logic [15:0] BYTE_OPS  = 16'h6000;
    localparam logic [15:0] REG_OPS   = 16'hCA72;
    localparam logic [15:0] SP_OPS    = 16'h0007;
    localparam logic [15:0] STACK_OPS = 16'h0003;
    localparam logic [3:0]  OP_BNC    = 4'd10;
    localparam logic [3:0]  OP_BC     = 4'd12;

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_EXEC   = 4'd3,
        S_MEM    = 4'd4,
        S_WB     = 4'd5,
        S_BRANCH = 4'd6
    } state_t;

    state_t              state, state_n;
    logic [BEAT_W-1:0]   beat_q, beat_n;
    logic                gap_q, gap_n;
    logic                halt_q, halt_n;
    logic                imem_req_n, alu_en_n, flag_we_n, reg_we_n, sp_we_n;
    logic                pc_inc_n, pc_load_n, dmem_req_n, dmem_we_n, dmem_byte_n;
    logic                start_ok;
`ifdef MEM_TIMEOUT_EN
    logic [7:0]          wait_q, wait_n;
    logic                err_n;
    assign start_ok = start && !bus_err;
`else
    assign start_ok = start;
`endif

    // The IR must capture the word during the acknowledge cycle itself
    assign ir_load = imem_req && imem_ack;
    assign beat    = 1'(beat_q);
    assign state_o = state;

    always_comb begin
        state_n     = state;
        beat_n      = beat_q;
        gap_n       = 1'b0;
        halt_n      = halt_q;
        imem_req_n  = 1'b0;
        alu_en_n    = 1'b0;
        flag_we_n   = 1'b0;
        reg_we_n    = 1'b0;
        sp_we_n     = 1'b0;
        pc_inc_n    = 1'b0;
        pc_load_n   = 1'b0;
        dmem_req_n  = 1'b0;
        dmem_we_n   = 1'b0;
        dmem_byte_n = 1'b0;
`ifdef MEM_TIMEOUT_EN
        wait_n      = 8'd0;
        err_n       = bus_err;
`endif
        case (state)
            S_IDLE: begin
                halt_n = 1'b0;
                if (start_ok) state_n = S_FETCH;
            end
            S_FETCH: begin
                if (imem_req && imem_ack) state_n = S_DECODE;
`ifdef MEM_TIMEOUT_EN
                else if (wait_q == 8'(TIMEOUT - 1)) begin
                    err_n   = 1'b1;
                    state_n = S_IDLE;
                end else begin
                    wait_n = 8'(wait_q + 8'd1);
                end
`endif
            end
            S_DECODE: begin
                halt_n  = halt_q | halt_req;
                state_n = S_EXEC;
            end
            S_EXEC: begin
                halt_n = halt_q | halt_req;
                if (MEM_OPS[opcode])                          state_n = S_MEM;
                else if (opcode == OP_BNC)                    state_n = S_BRANCH;
                else if ((opcode == OP_BC) && cond_true)      state_n = S_BRANCH;
                else                                          state_n = S_WB;
            end
            S_MEM: begin
                halt_n = halt_q | halt_req;
                if (gap_q) begin
                    gap_n = 1'b0;
                end else if (dmem_req && dmem_ack) begin
                    if (STACK_OPS[opcode] && (32'(beat_q) < PUSH_BEATS - 1)) begin
                        beat_n = BEAT_W'(beat_q + 1'b1);
                        gap_n  = 1'b1;
                    end else begin
                        beat_n  = '0;
                        state_n = S_WB;
                    end
                end
`ifdef MEM_TIMEOUT_EN
                else if (wait_q == 8'(TIMEOUT - 1)) begin
                    err_n   = 1'b1;
                    beat_n  = '0;
                    halt_n  = 1'b0;
                    state_n = S_IDLE;
                end else begin
                    wait_n = 8'(wait_q + 8'd1);
                end
`endif
            end
            S_WB, S_BRANCH: begin
                halt_n  = 1'b0;
                state_n = (halt_q || halt_req) ? S_IDLE : S_FETCH;
            end
            default: begin
                halt_n  = 1'b0;
                beat_n  = '0;
                state_n = S_IDLE;
            end
        endcase

        // Moore strobes for the state being entered, registered below
        case (state_n)
            S_FETCH:  imem_req_n = 1'b1;
            S_EXEC: begin
                alu_en_n  = ALU_OPS[opcode];
                flag_we_n = FLAG_OPS[opcode];
            end
            S_MEM: begin
                dmem_req_n  = !gap_n;
                dmem_we_n   = WR_OPS[opcode];
                dmem_byte_n = BYTE_OPS[opcode];
            end
            S_WB: begin
                reg_we_n = REG_OPS[opcode];
                sp_we_n  = SP_OPS[opcode];
                pc_inc_n = (PC_STEP != 0);
            end
            S_BRANCH: pc_load_n = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state     <= S_IDLE;
            beat_q    <= '0;
            gap_q     <= 1'b0;
            halt_q    <= 1'b0;
            imem_req  <= 1'b0;
            alu_en    <= 1'b0;
            flag_we   <= 1'b0;
            reg_we    <= 1'b0;
            sp_we     <= 1'b0;
            pc_inc    <= 1'b0;
            pc_load   <= 1'b0;
            dmem_req  <= 1'b0;
            dmem_we   <= 1'b0;
            dmem_byte <= 1'b0;
            busy      <= 1'b0;
`ifdef MEM_TIMEOUT_EN
            wait_q    <= 8'd0;
            bus_err   <= 1'b0;
`endif
        end else begin
            state     <= state_n;
            beat_q    <= beat_n;
            gap_q     <= gap_n;
            halt_q    <= halt_n;
            imem_req  <= imem_req_n;
            alu_en    <= alu_en_n;
            flag_we   <= flag_we_n;
            reg_we    <= reg_we_n;
            sp_we     <= sp_we_n;
            pc_inc    <= pc_inc_n;
            pc_load   <= pc_load_n;
            dmem_req  <= dmem_req_n;
            dmem_we   <= dmem_we_n;
            dmem_byte <= dmem_byte_n;
            busy      <= (state_n != S_IDLE);
`ifdef MEM_TIMEOUT_EN
            wait_q    <= wait_n;
            bus_err   <= err_n;
`endif
        end
    end

endmodule
